starfield_speed_ctrl: RTL and testbench

- Frame-synchronous speed sequencer for the starfield generator.
- CPU programs a target speed, step size and frames-per-step through a small register port.
- On each vblank rising edge, the block steps the live speed toward the target and issues single-cycle writes on the starfield's 8-bit speed port (data/write).
- The starfield sees smooth accelerate/decelerate ramps without per-frame CPU work.

---
 rtl/starfield_speed_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_starfield_speed_ctrl.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/starfield_speed_ctrl.sv
// starfield_speed_ctrl
//   Frame-synchronous speed sequencer for the starfield generator. The CPU programs a
//   target speed, a step size and a frames-per-step divider. On every qualifying vblank
//   rising edge the live speed is stepped toward the target, and each change is pushed
//   to the starfield's speed port as a single-cycle write.
//
// Ports
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   vblank     vertical blank level; the rising edge is detected internally
//   cpu_addr   register select: 0 target, 1 step, 2 divider, 3 control
//   cpu_data   CPU write data
//   cpu_write  CPU write strobe (one cycle)
//   sf_speed   speed value presented to the starfield data_in (held between writes)
//   sf_write   one-cycle write strobe to the starfield
//   busy       high while the current speed differs from the target
//   cur_speed  live current speed

module starfield_speed_ctrl #(
    parameter int unsigned DIV_W      = 4,
    parameter logic [7:0]  INIT_SPEED = 8'd0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       vblank,
    input  logic [1:0] cpu_addr,
    input  logic [7:0] cpu_data,
    input  logic       cpu_write,
    output logic [7:0] sf_speed,
    output logic       sf_write,
    output logic       busy,
    output logic [7:0] cur_speed
);

    typedef enum logic [1:0] {StInit, StIdle, StCalc, StWrite} state_e;

    state_e           state_q, state_d;
    logic [7:0]       target_q, target_d;
    logic [7:0]       step_q, step_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic             enable_q, enable_d;
    logic             snap_q, snap_d;
    logic [7:0]       current_q, current_d;
    logic [DIV_W-1:0] frame_cnt_q, frame_cnt_d;
    logic             vbl_q;
    logic [7:0]       sf_speed_q, sf_speed_d;
    logic             sf_write_q, sf_write_d;

    // CPU register decode
    logic wr_target, wr_step, wr_div, wr_ctrl;
    assign wr_target = cpu_write && (cpu_addr == 2'd0);
    assign wr_step   = cpu_write && (cpu_addr == 2'd1);
    assign wr_div    = cpu_write && (cpu_addr == 2'd2);
    assign wr_ctrl   = cpu_write && (cpu_addr == 2'd3);

    logic vbl_rise;
    assign vbl_rise = vblank & ~vbl_q;

    // Frame divider: a programmed 0 behaves as 1. The increment is one bit wider so the
    // comparison never wraps.
    logic [DIV_W-1:0] div_eff;
    logic [DIV_W:0]   fc_inc;
    logic             frame_due;
    assign div_eff   = (div_q == '0) ? DIV_W'(1) : div_q;
    assign fc_inc    = {1'b0, frame_cnt_q} + (DIV_W + 1)'(1);
    assign frame_due = fc_inc >= {1'b0, div_eff};

    // Next speed: move by step toward target, clamping at target so we never overshoot
    // and never wrap past 0 or 255.
    logic [8:0] sum9, diff9;
    logic [7:0] calc_speed;
    assign sum9  = {1'b0, current_q} + {1'b0, step_q};
    assign diff9 = {1'b0, current_q} - {1'b0, step_q};

    always_comb begin
        calc_speed = current_q;
        if (step_q == 8'd0) begin
            calc_speed = target_q;
        end else if (current_q < target_q) begin
            calc_speed = (sum9 > {1'b0, target_q}) ? target_q : sum9[7:0];
        end else if (current_q > target_q) begin
            calc_speed = (diff9[8] || (diff9[7:0] < target_q)) ? target_q : diff9[7:0];
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StInit;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StInit:  state_d = StIdle;
            StIdle: begin
                if (snap_q) begin
                    state_d = StWrite;
                end else if (vbl_rise && enable_q && frame_due) begin
                    state_d = StCalc;
                end
            end
            StCalc:  state_d = (calc_speed != current_q) ? StWrite : StIdle;
            StWrite: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Datapath and output next-values
    always_comb begin
        target_d    = target_q;
        step_d      = step_q;
        div_d       = div_q;
        enable_d    = enable_q;
        snap_d      = snap_q;
        current_d   = current_q;
        frame_cnt_d = frame_cnt_q;
        sf_speed_d  = sf_speed_q;
        sf_write_d  = 1'b0;

        if (wr_target) target_d = cpu_data;
        if (wr_step)   step_d   = cpu_data;
        if (wr_div)    div_d    = cpu_data[DIV_W-1:0];
        if (wr_ctrl)   enable_d = cpu_data[0];

        unique case (state_q)
            StInit: begin
                sf_speed_d = INIT_SPEED;
                sf_write_d = 1'b1;
            end
            StIdle: begin
                // Snap wins over a coincident vblank edge; that edge is dropped entirely.
                if (snap_q) begin
                    current_d = target_q;
                    snap_d    = 1'b0;
                end else if (vbl_rise && enable_q) begin
                    frame_cnt_d = frame_due ? '0 : fc_inc[DIV_W-1:0];
                end
            end
            StCalc: begin
                current_d = calc_speed;
            end
            StWrite: begin
                sf_speed_d = current_q;
                sf_write_d = 1'b1;
            end
            default: ;
        endcase

        if (wr_div) frame_cnt_d = '0;
        if (wr_ctrl && cpu_data[1]) snap_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            target_q    <= INIT_SPEED;
            step_q      <= 8'd1;
            div_q       <= DIV_W'(1);
            enable_q    <= 1'b0;
            snap_q      <= 1'b0;
            current_q   <= INIT_SPEED;
            frame_cnt_q <= '0;
            vbl_q       <= 1'b0;
            sf_speed_q  <= 8'd0;
            sf_write_q  <= 1'b0;
        end else begin
            target_q    <= target_d;
            step_q      <= step_d;
            div_q       <= div_d;
            enable_q    <= enable_d;
            snap_q      <= snap_d;
            current_q   <= current_d;
            frame_cnt_q <= frame_cnt_d;
            vbl_q       <= vblank;
            sf_speed_q  <= sf_speed_d;
            sf_write_q  <= sf_write_d;
        end
    end

    assign sf_speed  = sf_speed_q;
    assign sf_write  = sf_write_q;
    assign busy      = (current_q != target_q);
    assign cur_speed = current_q;

endmodule

// File: tb/tb_starfield_speed_ctrl.sv
module tb_starfield_speed_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       vblank = 1'b0;
    logic [1:0] cpu_addr = 2'd0;
    logic [7:0] cpu_data = 8'd0;
    logic       cpu_write = 1'b0;
    logic [7:0] sf_speed;
    logic       sf_write;
    logic       busy;
    logic [7:0] cur_speed;

    always #5 clk = ~clk;

    starfield_speed_ctrl #(
        .DIV_W      (4),
        .INIT_SPEED (8'd0)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .vblank    (vblank),
        .cpu_addr  (cpu_addr),
        .cpu_data  (cpu_data),
        .cpu_write (cpu_write),
        .sf_speed  (sf_speed),
        .sf_write  (sf_write),
        .busy      (busy),
        .cur_speed (cur_speed)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_wr(input logic [1:0] a, input logic [7:0] d);
        cpu_write = 1'b1;
        cpu_addr  = a;
        cpu_data  = d;
        tick();
        cpu_write = 1'b0;
        tick();
        tick();
    endtask

    // Directed table: one record per operation (CPU write or one vblank pulse)
    typedef struct {
        bit         is_vbl;
        logic [1:0] addr;
        logic [7:0] data;
        bit         exp_wr;
        logic [7:0] exp_val;
        logic [7:0] exp_cur;
        bit         exp_busy;
    } vec_t;

    function automatic vec_t cw(input logic [1:0] a, input logic [7:0] d, input bit w,
                                input logic [7:0] val, input logic [7:0] cur, input bit b);
        vec_t v;
        v.is_vbl = 1'b0; v.addr = a; v.data = d;
        v.exp_wr = w; v.exp_val = val; v.exp_cur = cur; v.exp_busy = b;
        return v;
    endfunction

    function automatic vec_t vb(input bit w, input logic [7:0] val, input logic [7:0] cur,
                                input bit b);
        vec_t v;
        v.is_vbl = 1'b1; v.addr = 2'd0; v.data = 8'd0;
        v.exp_wr = w; v.exp_val = val; v.exp_cur = cur; v.exp_busy = b;
        return v;
    endfunction

    // Reference model for the random phase: architectural state only, stepped per event
    typedef struct {
        int due;
        int val;
    } exp_t;

    exp_t wq[$];
    int   m_cur, m_tgt, m_step, m_div, m_fc, cyc, last_ev;
    bit   m_en, m_prev_vbl;

    function automatic int approach(input int c, input int t, input int s);
        if (s == 0) return t;
        if (c < t) return (c + s > t) ? t : c + s;
        if (c > t) return (c - s < t) ? t : c - s;
        return c;
    endfunction

    task automatic rstep(input bit vbl, input bit we, input logic [1:0] a,
                         input logic [7:0] d);
        bit rise;
        bit exp_w;
        int eff;
        vblank    = vbl;
        cpu_write = we;
        cpu_addr  = a;
        cpu_data  = d;
        tick();
        cyc++;
        rise       = vbl && !m_prev_vbl;
        m_prev_vbl = vbl;
        if (we) begin
            case (a)
                2'd0: m_tgt = d;
                2'd1: m_step = d;
                2'd2: begin m_div = d & 8'h0f; m_fc = 0; end
                default: begin
                    m_en = d[0];
                    if (d[1]) begin
                        m_cur = m_tgt;
                        wq.push_back('{due: cyc + 2, val: m_tgt});
                        last_ev = cyc;
                    end
                end
            endcase
        end
        if (rise) begin
            last_ev = cyc;
            if (m_en) begin
                eff = (m_div == 0) ? 1 : m_div;
                m_fc++;
                if (m_fc >= eff) begin
                    int nxt;
                    m_fc = 0;
                    nxt  = approach(m_cur, m_tgt, m_step);
                    if (nxt != m_cur) begin
                        m_cur = nxt;
                        wq.push_back('{due: cyc + 2, val: nxt});
                    end
                end
            end
        end
        exp_w = (wq.size() > 0) && (wq[0].due == cyc);
        chk("rnd_write", sf_write, exp_w);
        if (exp_w) begin
            chk("rnd_speed", sf_speed, wq[0].val);
            void'(wq.pop_front());
        end
        if (wq.size() == 0 && (cyc - last_ev) >= 3) begin
            chk("rnd_cur", cur_speed, m_cur);
            chk("rnd_busy", busy, m_cur != m_tgt);
        end
    endtask

    initial begin
        vec_t       vecs[$];
        vec_t       v;
        int         wr_cnt;
        int         r;
        int         hold;
        int         cool;
        logic [1:0] a;
        logic [7:0] d;

        // Ramp 0 -> 64 in steps of 16
        vecs.push_back(cw(2'd1, 8'd16, 0, 0, 0, 0));
        vecs.push_back(cw(2'd2, 8'd1, 0, 0, 0, 0));
        vecs.push_back(cw(2'd0, 8'd64, 0, 0, 0, 1));
        vecs.push_back(cw(2'd3, 8'd1, 0, 0, 0, 1));
        vecs.push_back(vb(1, 16, 16, 1));
        vecs.push_back(vb(1, 32, 32, 1));
        vecs.push_back(vb(1, 48, 48, 1));
        vecs.push_back(vb(1, 64, 64, 0));
        vecs.push_back(vb(0, 0, 64, 0));
        // Saturation at 255, then borrow clamp going down
        vecs.push_back(cw(2'd0, 8'd250, 0, 0, 64, 1));
        vecs.push_back(cw(2'd3, 8'd3, 1, 250, 250, 0));
        vecs.push_back(cw(2'd0, 8'd255, 0, 0, 250, 1));
        vecs.push_back(vb(1, 255, 255, 0));
        vecs.push_back(cw(2'd1, 8'd100, 0, 0, 255, 0));
        vecs.push_back(cw(2'd0, 8'd3, 0, 0, 255, 1));
        vecs.push_back(vb(1, 155, 155, 1));
        vecs.push_back(vb(1, 55, 55, 1));
        vecs.push_back(vb(1, 3, 3, 0));
        // Divider of 3
        vecs.push_back(cw(2'd0, 8'd0, 0, 0, 3, 1));
        vecs.push_back(cw(2'd3, 8'd3, 1, 0, 0, 0));
        vecs.push_back(cw(2'd1, 8'd8, 0, 0, 0, 0));
        vecs.push_back(cw(2'd2, 8'd3, 0, 0, 0, 0));
        vecs.push_back(cw(2'd0, 8'd24, 0, 0, 0, 1));
        vecs.push_back(vb(0, 0, 0, 1));
        vecs.push_back(vb(0, 0, 0, 1));
        vecs.push_back(vb(1, 8, 8, 1));
        vecs.push_back(vb(0, 0, 8, 1));
        vecs.push_back(vb(0, 0, 8, 1));
        vecs.push_back(vb(1, 16, 16, 1));
        vecs.push_back(vb(0, 0, 16, 1));
        vecs.push_back(vb(0, 0, 16, 1));
        vecs.push_back(vb(1, 24, 24, 0));
        // Divider written as 0 acts as 1
        vecs.push_back(cw(2'd0, 8'd40, 0, 0, 24, 1));
        vecs.push_back(cw(2'd2, 8'd0, 0, 0, 24, 1));
        vecs.push_back(vb(1, 32, 32, 1));
        vecs.push_back(vb(1, 40, 40, 0));
        // Disable mid-ramp freezes, snap jumps to target
        vecs.push_back(cw(2'd0, 8'd200, 0, 0, 40, 1));
        vecs.push_back(vb(1, 48, 48, 1));
        vecs.push_back(cw(2'd3, 8'd0, 0, 0, 48, 1));
        for (int i = 0; i < 4; i++) vecs.push_back(vb(0, 0, 48, 1));
        vecs.push_back(cw(2'd3, 8'd2, 1, 200, 200, 0));
        vecs.push_back(cw(2'd3, 8'd1, 0, 0, 200, 0));

        // Reset state and the single INIT write
        tick();
        tick();
        chk("rst_write", sf_write, 0);
        chk("rst_speed", sf_speed, 0);
        chk("rst_cur", cur_speed, 0);
        chk("rst_busy", busy, 0);
        rst_n = 1'b1;
        tick();
        chk("init_write", sf_write, 1);
        chk("init_speed", sf_speed, 0);
        wr_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (sf_write) wr_cnt++;
        end
        chk("init_single", wr_cnt, 0);
        chk("init_busy", busy, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            if (v.is_vbl) begin
                vblank = 1'b1;
            end else begin
                cpu_write = 1'b1;
                cpu_addr  = v.addr;
                cpu_data  = v.data;
            end
            tick();
            vblank    = 1'b0;
            cpu_write = 1'b0;
            chk($sformatf("vec%0d_wr_e1", i), sf_write, 0);
            tick();
            chk($sformatf("vec%0d_wr_e2", i), sf_write, 0);
            tick();
            chk($sformatf("vec%0d_wr_e3", i), sf_write, v.exp_wr);
            if (v.exp_wr) chk($sformatf("vec%0d_speed", i), sf_speed, v.exp_val);
            tick();
            chk($sformatf("vec%0d_wr_e4", i), sf_write, 0);
            chk($sformatf("vec%0d_cur", i), cur_speed, v.exp_cur);
            chk($sformatf("vec%0d_busy", i), busy, v.exp_busy);
        end

        // Target written during CALC: this step uses the old target (100)
        cpu_wr(2'd1, 8'd10);
        cpu_wr(2'd0, 8'd100);
        vblank = 1'b1;
        tick();
        vblank    = 1'b0;
        cpu_write = 1'b1;
        cpu_addr  = 2'd0;
        cpu_data  = 8'd250;
        tick();
        cpu_write = 1'b0;
        tick();
        chk("calc_old_tgt_wr", sf_write, 1);
        chk("calc_old_tgt_val", sf_speed, 190);
        tick();
        tick();
        vblank = 1'b1;
        tick();
        vblank = 1'b0;
        tick();
        tick();
        chk("calc_new_tgt_wr", sf_write, 1);
        chk("calc_new_tgt_val", sf_speed, 200);
        tick();
        tick();

        // Reset while the write strobe is high
        vblank = 1'b1;
        tick();
        vblank = 1'b0;
        tick();
        tick();
        chk("rstw_pre_wr", sf_write, 1);
        chk("rstw_pre_val", sf_speed, 210);
        #2 rst_n = 1'b0;
        #1;
        chk("rstw_async_wr", sf_write, 0);
        chk("rstw_async_cur", cur_speed, 0);
        chk("rstw_async_busy", busy, 0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("rstw_init_wr", sf_write, 1);
        chk("rstw_init_val", sf_speed, 0);
        tick();
        chk("rstw_init_end", sf_write, 0);

        // Randomized phase against the reference model
        m_cur = 0; m_tgt = 0; m_step = 1; m_div = 1; m_fc = 0; m_en = 1'b0;
        m_prev_vbl = 1'b0; cyc = 0; last_ev = 0;
        hold = 0;
        cool = 0;
        for (int k = 0; k < 4000; k++) begin
            if (hold > 0) begin
                hold--;
                rstep(1'b1, 1'b0, 2'd0, 8'd0);
            end else if (cool > 0) begin
                cool--;
                rstep(1'b0, 1'b0, 2'd0, 8'd0);
            end else begin
                r = $urandom_range(0, 9);
                if (r < 3) begin
                    hold = $urandom_range(0, 2);
                    cool = 4;
                    rstep(1'b1, 1'b0, 2'd0, 8'd0);
                end else if (r < 6) begin
                    a = 2'($urandom_range(0, 3));
                    case (a)
                        2'd0: d = 8'($urandom_range(0, 255));
                        2'd1: d = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 60));
                        2'd2: d = 8'($urandom_range(0, 4));
                        default: begin
                            d    = 8'($urandom);
                            d[0] = ($urandom_range(0, 4) != 0);
                            d[1] = ($urandom_range(0, 4) == 0);
                        end
                    endcase
                    if (a == 2'd3 && d[1]) cool = 4;
                    rstep(1'b0, 1'b1, a, d);
                end else begin
                    rstep(1'b0, 1'b0, 2'd0, 8'd0);
                end
            end
        end
        for (int k = 0; k < 6; k++) rstep(1'b0, 1'b0, 2'd0, 8'd0);
        chk("rnd_drain", wq.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
